// File: rtl/npu_done_reporter_if.sv
// Completion-event handshake plus done-SRAM port-2 signals for npu_done_reporter.
// slave is the reporter's view; master is the event source / SRAM side.
interface npu_done_reporter_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [8:0] evt_job;
  logic [6:0] evt_status;
  logic [8:0] address2;
  logic       chipselect2;
  logic       write2;
  logic [7:0] writedata2;
  logic       clken2;
  logic [7:0] readdata2;

  modport slave (
    input  evt_valid, evt_job, evt_status, readdata2,
    output evt_ready, address2, chipselect2, write2, writedata2, clken2
  );

  modport master (
    output evt_valid, evt_job, evt_status, readdata2,
    input  evt_ready, address2, chipselect2, write2, writedata2, clken2
  );
endinterface

// File: rtl/npu_done_reporter.sv
// Buffers NPU completion events and posts each one into its done-SRAM slot,
// polling a still-pending slot up to POLL_LIMIT times before overwriting it.
//
// state | meaning
// IDLE  | waiting for a buffered event
// RD    | reading the head job's slot
// CHK   | read data returning; decide retry, write or forced write
// WR    | writing {1,status} to the slot and popping the event
module npu_done_reporter #(
  parameter int FIFO_DEPTH = 4,
  parameter int POLL_LIMIT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  npu_done_reporter_if.slave   bus,
  output logic                 busy,
  output logic [15:0]          overwrite_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  POLL_MAX = 8'(POLL_LIMIT);

  typedef enum logic [1:0] {IDLE, RD, CHK, WR} state_t;

  state_t        state;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    poll_cnt;
  logic          push;
  logic          pop;
  logic [8:0]    head_job;
  logic [6:0]    head_status;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even on the cycle it pops.
  assign bus.evt_ready = !reset && (count < DEPTH_C);
  assign bus.clken2    = 1'b1;
  assign push          = bus.evt_valid && bus.evt_ready;
  assign pop           = (state == WR);
  assign head_job      = fifo_mem[rd_ptr][15:7];
  assign head_status   = fifo_mem[rd_ptr][6:0];
  assign busy          = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.evt_job, bus.evt_status};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      poll_cnt        <= '0;
      overwrite_cnt   <= '0;
      bus.address2    <= '0;
      bus.writedata2  <= '0;
      bus.chipselect2 <= 1'b0;
      bus.write2      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state           <= RD;
            poll_cnt        <= '0;
            bus.address2    <= head_job;
            bus.chipselect2 <= 1'b1;
            bus.write2      <= 1'b0;
          end
        end
        RD: begin
          state           <= CHK;
          bus.chipselect2 <= 1'b0;
          bus.write2      <= 1'b0;
        end
        CHK: begin
          if (bus.readdata2 != 8'h00 && poll_cnt < POLL_MAX) begin
            state           <= RD;
            poll_cnt        <= poll_cnt + 8'd1;
            bus.address2    <= head_job;
            bus.chipselect2 <= 1'b1;
            bus.write2      <= 1'b0;
          end else begin
            // Host never freed the slot: force the write and count it.
            if (bus.readdata2 != 8'h00 && overwrite_cnt != 16'hFFFF)
              overwrite_cnt <= overwrite_cnt + 16'd1;
            state           <= WR;
            bus.address2    <= head_job;
            bus.writedata2  <= {1'b1, head_status};
            bus.chipselect2 <= 1'b1;
            bus.write2      <= 1'b1;
          end
        end
        WR: begin
          state           <= IDLE;
          bus.chipselect2 <= 1'b0;
          bus.write2      <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          bus.chipselect2 <= 1'b0;
          bus.write2      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_npu_done_reporter.sv
// Directed bench for npu_done_reporter with a behavioural done-SRAM on port 2.
module tb_npu_done_reporter;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [15:0] overwrite_cnt;

  npu_done_reporter_if bus ();

  npu_done_reporter #(.FIFO_DEPTH(4), .POLL_LIMIT(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .busy          (busy),
    .overwrite_cnt (overwrite_cnt)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, optional host clear after a given read
  logic [7:0] mem [512];
  logic       mem_init;
  logic       host_wr;
  logic [8:0] host_addr;
  logic [7:0] host_data;
  int         clear_at;
  int         rd_total;
  int         wr_n;
  logic [8:0] wr_addr [64];
  logic [7:0] wr_data [64];

  initial begin
    rd_total = 0;
    wr_n     = 0;
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else begin
      if (host_wr) mem[host_addr] <= host_data;
      if (bus.chipselect2 && bus.write2) begin
        mem[bus.address2] <= bus.writedata2;
        if (wr_n < 64) begin
          wr_addr[wr_n] <= bus.address2;
          wr_data[wr_n] <= bus.writedata2;
        end
        wr_n <= wr_n + 1;
      end else if (bus.chipselect2) begin
        bus.readdata2 <= mem[bus.address2];
        rd_total      <= rd_total + 1;
        if (clear_at != 0 && rd_total + 1 == clear_at) mem[bus.address2] <= 8'h00;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic saw_full;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [8:0] a, input logic [7:0] d);
    host_addr = a;
    host_data = d;
    host_wr   = 1'b1;
    tick();
    host_wr   = 1'b0;
  endtask

  task automatic send_evt(input logic [8:0] job, input logic [6:0] status);
    int n = 0;
    bus.evt_valid  = 1'b1;
    bus.evt_job    = job;
    bus.evt_status = status;
    while (!bus.evt_ready && n < 50) begin
      saw_full = 1'b1;
      tick();
      n++;
    end
    chk("evt_accept", {31'd0, bus.evt_ready}, 32'd1);
    tick();
    bus.evt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  int rd0;
  int wr0;

  initial begin
    reset          = 1'b1;
    mem_init       = 1'b1;
    host_wr        = 1'b0;
    host_addr      = '0;
    host_data      = '0;
    clear_at       = 0;
    saw_full       = 1'b0;
    bus.evt_valid  = 1'b0;
    bus.evt_job    = '0;
    bus.evt_status = '0;
    repeat (3) tick();

    chk("rst_evt_ready", {31'd0, bus.evt_ready},   32'd0);
    chk("rst_cs",        {31'd0, bus.chipselect2}, 32'd0);
    chk("rst_we",        {31'd0, bus.write2},      32'd0);
    chk("rst_addr",      {23'd0, bus.address2},    32'd0);
    chk("rst_wdata",     {24'd0, bus.writedata2},  32'd0);
    chk("rst_busy",      {31'd0, busy},            32'd0);
    chk("rst_ovw",       {16'd0, overwrite_cnt},   32'd0);
    chk("clken2",        {31'd0, bus.clken2},      32'd1);
    reset    = 1'b0;
    mem_init = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, bus.evt_ready}, 32'd1);

    // single event, free slot: read at N+1, write at N+3
    rd0 = rd_total;
    wr0 = wr_n;
    send_evt(9'h005, 7'h12);
    chk("s_busy",   {31'd0, busy},            32'd1);
    chk("s_idle_cs",{31'd0, bus.chipselect2}, 32'd0);
    tick();
    chk("s_rd_cs",  {31'd0, bus.chipselect2}, 32'd1);
    chk("s_rd_we",  {31'd0, bus.write2},      32'd0);
    chk("s_rd_addr",{23'd0, bus.address2},    32'h005);
    tick();
    chk("s_chk_cs", {31'd0, bus.chipselect2}, 32'd0);
    tick();
    chk("s_wr_cs",  {31'd0, bus.chipselect2}, 32'd1);
    chk("s_wr_we",  {31'd0, bus.write2},      32'd1);
    chk("s_wr_addr",{23'd0, bus.address2},    32'h005);
    chk("s_wr_data",{24'd0, bus.writedata2},  32'h92);
    tick();
    chk("s_end_cs", {31'd0, bus.chipselect2}, 32'd0);
    chk("s_end_we", {31'd0, bus.write2},      32'd0);
    chk("s_busy0",  {31'd0, busy},            32'd0);
    chk("s_addr_hold", {23'd0, bus.address2}, 32'h005);
    chk("s_mem",    {24'd0, mem[9'h005]},     32'h92);
    chk("s_reads",  rd_total - rd0,           32'd1);
    chk("s_writes", wr_n - wr0,               32'd1);

    // busy slot cleared by host after the second read
    host_write(9'h1FF, 8'h80);
    rd0      = rd_total;
    clear_at = rd_total + 2;
    send_evt(9'h1FF, 7'h05);
    wait_idle(200);
    clear_at = 0;
    chk("b_reads", rd_total - rd0,        32'd3);
    chk("b_mem",   {24'd0, mem[9'h1FF]},  32'h85);
    chk("b_ovw",   {16'd0, overwrite_cnt},32'd0);

    // stuck slot: forced overwrite after POLL_LIMIT+1 reads
    host_write(9'h1FF, 8'h80);
    rd0 = rd_total;
    send_evt(9'h1FF, 7'h33);
    wait_idle(200);
    chk("k_reads", rd_total - rd0,        32'd4);
    chk("k_mem",   {24'd0, mem[9'h1FF]},  32'hB3);
    chk("k_ovw",   {16'd0, overwrite_cnt},32'd1);

    // burst of 6 into a 4-deep FIFO
    wr0      = wr_n;
    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) send_evt(9'h010 + 9'(i), 7'h40 + 7'(i));
    wait_idle(300);
    chk("u_full_seen", {31'd0, saw_full}, 32'd1);
    chk("u_writes",    wr_n - wr0,        32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("u_addr%0d", i), {23'd0, wr_addr[wr0+i]}, 32'h010 + i);
      chk($sformatf("u_data%0d", i), {24'd0, wr_data[wr0+i]}, 32'hC0 + i);
    end

    // reset during CHK aborts the in-flight event
    wr0 = wr_n;
    send_evt(9'h020, 7'h01);
    tick();
    chk("r_rd_cs", {31'd0, bus.chipselect2}, 32'd1);
    tick();
    chk("r_chk_cs",{31'd0, bus.chipselect2}, 32'd0);
    reset = 1'b1;
    tick();
    chk("r_cs",    {31'd0, bus.chipselect2}, 32'd0);
    chk("r_we",    {31'd0, bus.write2},      32'd0);
    chk("r_busy",  {31'd0, busy},            32'd0);
    chk("r_ready", {31'd0, bus.evt_ready},   32'd0);
    chk("r_ovw",   {16'd0, overwrite_cnt},   32'd0);
    reset = 1'b0;
    repeat (6) tick();
    chk("r_no_write", wr_n - wr0,            32'd0);
    chk("r_mem",   {24'd0, mem[9'h020]},     32'h00);
    chk("r_idle",  {31'd0, busy},            32'd0);

    send_evt(9'h021, 7'h7F);
    wait_idle(200);
    chk("p_mem",    {24'd0, mem[9'h021]},    32'hFF);
    chk("p_writes", wr_n - wr0,              32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
